// File: rtl/ssd_source_sel.sv
// Display source selector: debounced NEXT/HOLD buttons pick and freeze a saturated 13-bit value for the SSD driver.
// Optional macro SSD_SRC_SIGNED_EN: ALU mode shows |alu_out| and flags negative values.
module ssd_source_sel #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_hold,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] alu_out,
    output logic [12:0] num,
    output logic [1:0]  mode,
    output logic        hold_active,
    output logic        overflow,
    output logic        negative
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] M_PC  = 2'd0;
    localparam logic [1:0] M_ILO = 2'd1;
    localparam logic [1:0] M_IHI = 2'd2;
    localparam logic [1:0] M_ALU = 2'd3;

    // Bit 0 is NEXT, bit 1 is HOLD throughout the button path.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r, sync2_r, deb_r, deb_q_r, pulse_r;
    logic [CW-1:0] cnt_r [2];

    logic [1:0]    mode_r, mode_n_s;
    logic          hold_r, hold_n_s;
    logic [12:0]   num_r, num_s;
    logic          ovf_r, ovf_s;
    logic          neg_r, neg_s;
    logic [31:0]   value_s;

    assign raw_s = {btn_hold, btn_next};

    // Synchronizers, debounce counters and registered rising-edge pulses for both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            deb_r    <= 2'b00;
            deb_q_r  <= 2'b00;
            pulse_r  <= 2'b00;
            cnt_r[0] <= '0;
            cnt_r[1] <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_q_r <= deb_r;
            pulse_r <= deb_r & ~deb_q_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Mode/hold state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= M_PC;
            hold_r <= 1'b0;
        end else begin
            mode_r <= mode_n_s;
            hold_r <= hold_n_s;
        end
    end

    // Next-state logic: a HOLD pulse wins over a simultaneous NEXT pulse.
    always_comb begin
        mode_n_s = mode_r;
        hold_n_s = hold_r;
        if (pulse_r[1]) begin
            hold_n_s = ~hold_r;
        end else if (pulse_r[0] && !hold_r) begin
            mode_n_s = mode_r + 2'd1;
        end else begin
            mode_n_s = mode_r;
        end
    end

    // Source select and saturation to the 13-bit display range.
    always_comb begin
        value_s = 32'd0;
        neg_s   = 1'b0;
        case (mode_r)
            M_PC:    value_s = pc;
            M_ILO:   value_s = {16'd0, instr[15:0]};
            M_IHI:   value_s = {16'd0, instr[31:16]};
            M_ALU: begin
`ifdef SSD_SRC_SIGNED_EN
                if (alu_out[31]) begin
                    value_s = 32'd0 - alu_out;
                    neg_s   = 1'b1;
                end else begin
                    value_s = alu_out;
                    neg_s   = 1'b0;
                end
`else
                value_s = alu_out;
`endif
            end
            default: value_s = 32'd0;
        endcase
        if (value_s > 32'd8191) begin
            num_s = 13'h1FFF;
            ovf_s = 1'b1;
        end else begin
            num_s = value_s[12:0];
            ovf_s = 1'b0;
        end
    end

    // Display value register, frozen while hold is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_r <= 13'd0;
            ovf_r <= 1'b0;
            neg_r <= 1'b0;
        end else if (!hold_r) begin
            num_r <= num_s;
            ovf_r <= ovf_s;
            neg_r <= neg_s;
        end
    end

    assign num         = num_r;
    assign mode        = mode_r;
    assign hold_active = hold_r;
    assign overflow    = ovf_r;
    assign negative    = neg_r;

endmodule

// File: tb/tb_ssd_source_sel.sv
// Randomized bench for ssd_source_sel (DEBOUNCE_CYCLES=4) against a window-based reference model.
module tb_ssd_source_sel;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst, btn_next, btn_hold;
    logic [31:0] pc, instr, alu_out;
    logic [12:0] num;
    logic [1:0]  mode;
    logic        hold_active, overflow, negative;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [1:0]    m_raw1, m_raw2;
    logic [DC-1:0] m_win [2];
    logic [1:0]    m_deb, m_d1, m_d2;
    logic [1:0]    m_mode;
    logic          m_hold, m_ovf, m_neg;
    logic [12:0]   m_num;

    ssd_source_sel #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_hold(btn_hold),
        .pc(pc), .instr(instr), .alu_out(alu_out),
        .num(num), .mode(mode), .hold_active(hold_active),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference, using the values the DUT sampled.
    task automatic model_edge();
        longint v;
        logic [1:0] apply, rise, smp;
        if (rst) begin
            m_raw1 = 2'b00; m_raw2 = 2'b00; m_win[0] = '0; m_win[1] = '0;
            m_deb = 2'b00; m_d1 = 2'b00; m_d2 = 2'b00;
            m_mode = 2'd0; m_hold = 1'b0; m_num = 13'd0; m_ovf = 1'b0; m_neg = 1'b0;
            return;
        end
        if (!m_hold) begin
            m_neg = 1'b0;
            if (m_mode == 2'd0)      v = pc;
            else if (m_mode == 2'd1) v = instr & 32'hFFFF;
            else if (m_mode == 2'd2) v = instr >> 16;
            else begin
                v = alu_out;
`ifdef SSD_SRC_SIGNED_EN
                if ($signed(alu_out) < 0) begin
                    v = -longint'($signed(alu_out));
                    m_neg = 1'b1;
                end
`endif
            end
            m_ovf = (v > 8191);
            m_num = m_ovf ? 13'd8191 : 13'(v);
        end
        apply = m_d2;
        if (apply[1])                m_hold = ~m_hold;
        else if (apply[0] && !m_hold) m_mode = m_mode + 2'd1;
        rise = 2'b00;
        smp  = m_raw2;
        for (int i = 0; i < 2; i++) begin
            m_win[i] = {m_win[i][DC-2:0], smp[i]};
            if ((m_deb[i] && m_win[i] == '0) || (!m_deb[i] && m_win[i] == '1)) begin
                m_deb[i] = smp[i];
                rise[i]  = smp[i];
            end
        end
        m_d2 = m_d1;
        m_d1 = rise;
        m_raw2 = m_raw1;
        m_raw1 = {btn_hold, btn_next};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("num", 32'(num), 32'(m_num));
        check("mode", 32'(mode), 32'(m_mode));
        check("hold", 32'(hold_active), 32'(m_hold));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("neg", 32'(negative), 32'(m_neg));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit hold_btn);
        if (hold_btn) btn_hold = 1'b1; else btn_next = 1'b1;
        ticks(8);
        btn_hold = 1'b0; btn_next = 1'b0;
        ticks(8);
    endtask

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_hold = 1'b0;
        pc = 32'd100; instr = 32'd0; alu_out = 32'd0;
        ticks(2);
        check("rst_num", 32'(num), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_num", 32'(num), 32'd100);
        check("post_rst_ovf", 32'(overflow), 32'd0);

        // Clean press: mode advances at the 8th edge (edge 7)
        btn_next = 1'b1;
        ticks(7);
        check("mode_edge6", 32'(mode), 32'd0);
        tick();
        check("mode_edge7", 32'(mode), 32'd1);
        instr = 32'h0012_0ABC;
        tick();
        check("instr_lo", 32'(num), 32'd2748);
        btn_next = 1'b0;
        ticks(10);

        // Bounce shorter than the debounce window
        for (int k = 0; k < 3; k++) begin
            btn_next = 1'b1; ticks(2);
            btn_next = 1'b0; ticks(2);
        end
        ticks(10);
        check("bounce_mode", 32'(mode), 32'd1);

        press(1'b0); check("mode2", 32'(mode), 32'd2);
        press(1'b0); check("mode3", 32'(mode), 32'd3);
        press(1'b0); check("mode_wrap", 32'(mode), 32'd0);
        pc = 32'd9000; ticks(2);
        check("sat_num", 32'(num), 32'd8191);
        check("sat_ovf", 32'(overflow), 32'd1);

        // Hold freezes the display and blocks NEXT
        pc = 32'd100; ticks(2);
        press(1'b1);
        check("hold_on", 32'(hold_active), 32'd1);
        pc = 32'd200; ticks(3);
        check("hold_num", 32'(num), 32'd100);
        press(1'b0);
        check("hold_next_ign", 32'(mode), 32'd0);
        press(1'b1);
        check("hold_off_num", 32'(num), 32'd200);

        // ALU mode with a negative result
        alu_out = 32'hFFFF_FFE7;
        press(1'b0); press(1'b0); press(1'b0);
        ticks(2);
`ifdef SSD_SRC_SIGNED_EN
        check("alu_neg_num", 32'(num), 32'd25);
        check("alu_neg_flag", 32'(negative), 32'd1);
`else
        check("alu_uns_num", 32'(num), 32'd8191);
        check("alu_uns_ovf", 32'(overflow), 32'd1);
        check("alu_uns_neg", 32'(negative), 32'd0);
`endif

        // Reset in the middle of a debounce discards the press
        btn_next = 1'b1; ticks(4);
        rst = 1'b1; tick();
        rst = 1'b0; btn_next = 1'b0; ticks(10);
        check("rst_mid_mode", 32'(mode), 32'd0);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_hold = ~btn_hold;
            rst = ($urandom_range(0, 499) == 0);
            pc    = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 9000);
            instr = $urandom;
            case ($urandom_range(0, 3))
                0: alu_out = $urandom_range(0, 9000);
                1: alu_out = 32'd0 - $urandom_range(0, 9000);
                2: alu_out = 32'h8000_0000;
                default: alu_out = $urandom;
            endcase
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
